// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite fetch block.
// Holds the default sprite geometry and transparent colour key, the raster
// timing constants, the register address map, the commit FSM state type and
// the RGB565 channel expansion helpers.
package sprite_pkg;

    localparam int          SPR_W    = 32;
    localparam int          SPR_H    = 32;
    localparam logic [15:0] KEY      = 16'hF81F;

    localparam logic [10:0] HACTIVE  = 11'd1280;
    localparam logic [9:0]  VACTIVE  = 10'd480;
    localparam logic [10:0] HTOTAL   = 11'd1600;

    typedef enum logic [2:0] {
        REG_X_LO   = 3'd0,
        REG_X_HI   = 3'd1,
        REG_Y_LO   = 3'd2,
        REG_Y_HI   = 3'd3,
        REG_ENABLE = 3'd4
    } reg_addr_e;

    typedef enum logic {
        CLEAN = 1'b0,
        DIRTY = 1'b1
    } commit_state_e;

    // Replicate the top bits into the low bits so that full scale maps to 8'hFF.
    function automatic logic [7:0] expand5(input logic [4:0] c);
        return {c, c[4:2]};
    endfunction

    function automatic logic [7:0] expand6(input logic [5:0] c);
        return {c, c[5:4]};
    endfunction

endpackage

// File: rtl/sprite_regs.sv
// Sprite position/enable registers with frame-synchronous commit.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   chipselect, write, address,
//   writedata                    Avalon slave write port (8-bit registers)
//   hcount, vcount               raster position, used to find the frame boundary
//   x_active, y_active,
//   en_active                    values the pixel pipeline uses this frame
// Software writes land in a pending copy; the active copy only changes on the
// last pixel of the visible frame, so a sprite never tears mid-frame.
module sprite_regs (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        chipselect,
    input  logic        write,
    input  logic [2:0]  address,
    input  logic [7:0]  writedata,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    output logic [9:0]  x_active,
    output logic [9:0]  y_active,
    output logic        en_active
);
    import sprite_pkg::*;

    commit_state_e state, state_next;

    logic [9:0] x_pend;
    logic [9:0] y_pend;
    logic       en_pend;
    logic       wr_strobe;
    logic       frame_end;
    logic       commit;

    assign wr_strobe = chipselect && write;
    assign frame_end = (hcount == HTOTAL - 11'd1) && (vcount == VACTIVE - 10'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= CLEAN;
        end else begin
            state <= state_next;
        end
    end

    // A write arriving in the boundary cycle wins over the commit's return to
    // CLEAN, so the freshly written value is picked up one frame later.
    always_comb begin
        state_next = state;
        commit     = 1'b0;
        case (state)
            CLEAN: begin
                if (wr_strobe) begin
                    state_next = DIRTY;
                end
            end
            DIRTY: begin
                if (frame_end) begin
                    commit     = 1'b1;
                    state_next = CLEAN;
                end
                if (wr_strobe) begin
                    state_next = DIRTY;
                end
            end
            default: state_next = CLEAN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_pend  <= '0;
            y_pend  <= '0;
            en_pend <= 1'b0;
        end else if (wr_strobe) begin
            case (reg_addr_e'(address))
                REG_X_LO:   x_pend[7:0] <= writedata;
                REG_X_HI:   x_pend[9:8] <= writedata[1:0];
                REG_Y_LO:   y_pend[7:0] <= writedata;
                REG_Y_HI:   y_pend[9:8] <= writedata[1:0];
                REG_ENABLE: en_pend     <= writedata[0];
                default:    ;
            endcase
        end
    end

    // Commit samples the pending copy before this cycle's write takes effect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_active  <= '0;
            y_active  <= '0;
            en_active <= 1'b0;
        end else if (commit) begin
            x_active  <= x_pend;
            y_active  <= y_pend;
            en_active <= en_pend;
        end
    end

endmodule

// File: rtl/sprite_fetch.sv
// Single-sprite fetch pipeline for a 640x480 raster (hcount runs at 2x pixel).
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   chipselect, write, address,
//   writedata                    register write port (see sprite_regs)
//   hcount, vcount               raster position; pixel column = hcount[10:1]
//   rom_addr                     sprite ROM word address (row offset : col offset)
//   rom_data                     RGB565 word, valid one clock after rom_addr
//   pix_r, pix_g, pix_b          expanded 8-bit colour, zero when not valid
//   pix_valid                    sprite covers the pixel and it is opaque
// Latency from hcount/vcount to pix_* is three clocks, with no stalls.
module sprite_fetch #(
    parameter int          SPR_W = sprite_pkg::SPR_W,
    parameter int          SPR_H = sprite_pkg::SPR_H,
    parameter logic [15:0] KEY   = sprite_pkg::KEY
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        chipselect,
    input  logic        write,
    input  logic [2:0]  address,
    input  logic [7:0]  writedata,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    output logic [9:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic [7:0]  pix_r,
    output logic [7:0]  pix_g,
    output logic [7:0]  pix_b,
    output logic        pix_valid
);
    import sprite_pkg::*;

    localparam int XB = $clog2(SPR_W);
    localparam int YB = $clog2(SPR_H);

    logic [9:0]       x_active;
    logic [9:0]       y_active;
    logic             en_active;
    logic [10:0]      col;
    logic [10:0]      row;
    logic [10:0]      x_ext;
    logic [10:0]      y_ext;
    logic             hit;
    logic             hit1;
    logic             hit2;
    logic [XB-1:0]    col_off;
    logic [YB-1:0]    row_off;
    logic [YB+XB-1:0] tile_idx;

    sprite_regs u_regs (
        .clk        (clk),
        .reset_n    (reset_n),
        .chipselect (chipselect),
        .write      (write),
        .address    (address),
        .writedata  (writedata),
        .hcount     (hcount),
        .vcount     (vcount),
        .x_active   (x_active),
        .y_active   (y_active),
        .en_active  (en_active)
    );

    // Compares run in 11 bits so x+SPR_W past column 1023 cannot wrap back
    // onto the left edge; the same holds vertically.
    assign col   = {1'b0, hcount[10:1]};
    assign row   = {1'b0, vcount};
    assign x_ext = {1'b0, x_active};
    assign y_ext = {1'b0, y_active};

    assign hit = en_active
              && (hcount < HACTIVE) && (vcount < VACTIVE)
              && (col >= x_ext) && (col < x_ext + 11'(SPR_W))
              && (row >= y_ext) && (row < y_ext + 11'(SPR_H));

    // Only the low bits of the offsets address the ROM, so subtract just those.
    assign col_off  = hcount[XB:1] - x_active[XB-1:0];
    assign row_off  = vcount[YB-1:0] - y_active[YB-1:0];
    assign tile_idx = {row_off, col_off};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr  <= '0;
            hit1      <= 1'b0;
            hit2      <= 1'b0;
            pix_valid <= 1'b0;
            pix_r     <= '0;
            pix_g     <= '0;
            pix_b     <= '0;
        end else begin
            if (hit) begin
                rom_addr <= 10'(tile_idx);
            end
            hit1 <= hit;
            hit2 <= hit1;
            if (hit2 && (rom_data != KEY)) begin
                pix_valid <= 1'b1;
                pix_r     <= expand5(rom_data[15:11]);
                pix_g     <= expand6(rom_data[10:5]);
                pix_b     <= expand5(rom_data[4:0]);
            end else begin
                pix_valid <= 1'b0;
                pix_r     <= '0;
                pix_g     <= '0;
                pix_b     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sprite_fetch.sv
// Testbench for sprite_fetch: directed raster scans plus randomized register
// writes and raster positions, compared every cycle against a behavioural
// model of sprite coverage, frame-synchronous commit and colour expansion.
`timescale 1ns/1ps
module tb_sprite_fetch;

    localparam int          SPR_W = 32;
    localparam int          SPR_H = 32;
    localparam logic [15:0] KEY   = 16'hF81F;

    logic        clk;
    logic        reset_n;
    logic        chipselect;
    logic        write;
    logic [2:0]  address;
    logic [7:0]  writedata;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [9:0]  rom_addr;
    logic [15:0] rom_data;
    logic [7:0]  pix_r;
    logic [7:0]  pix_g;
    logic [7:0]  pix_b;
    logic        pix_valid;

    logic [15:0] rom_mem [0:1023];

    int check_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int vis_count = 0;

    // Reference model state
    int   m_pend_x, m_pend_y, m_act_x, m_act_y, m_addr;
    bit   m_pend_en, m_act_en, m_dirty;
    bit   d_valid [3];
    logic [7:0] d_r [3];
    logic [7:0] d_g [3];
    logic [7:0] d_b [3];

    sprite_fetch #(.SPR_W(SPR_W), .SPR_H(SPR_H), .KEY(KEY)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .chipselect (chipselect),
        .write      (write),
        .address    (address),
        .writedata  (writedata),
        .hcount     (hcount),
        .vcount     (vcount),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .pix_r      (pix_r),
        .pix_g      (pix_g),
        .pix_b      (pix_b),
        .pix_valid  (pix_valid)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Synchronous sprite ROM: data follows the address by one clock.
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    task automatic checkValue(input string tag, input logic [15:0] obs, input logic [15:0] expected);
        check_cnt++;
        assert (obs === expected) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed %h, expected %h at %0t", tag, obs, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_pend_x = 0; m_pend_y = 0; m_pend_en = 0;
        m_act_x  = 0; m_act_y  = 0; m_act_en  = 0;
        m_dirty  = 0; m_addr   = 0;
        for (int i = 0; i < 3; i++) begin
            d_valid[i] = 0; d_r[i] = 0; d_g[i] = 0; d_b[i] = 0;
        end
    endtask

    // One clock of the model: which sprite texel (if any) sits under the raster,
    // what colour it becomes three clocks later, then commit and register write.
    task automatic modelEdge(input int h, input int v, input bit wr, input int a, input int d);
        int col, row, addr, r5, g6, b5;
        bit hit;
        logic [15:0] w;
        col = h / 2;
        row = v;
        hit = m_act_en && (h < 1280) && (v < 480)
           && (col >= m_act_x) && (col < m_act_x + SPR_W)
           && (row >= m_act_y) && (row < m_act_y + SPR_H);
        for (int i = 2; i > 0; i--) begin
            d_valid[i] = d_valid[i-1]; d_r[i] = d_r[i-1]; d_g[i] = d_g[i-1]; d_b[i] = d_b[i-1];
        end
        d_valid[0] = 0; d_r[0] = 0; d_g[0] = 0; d_b[0] = 0;
        if (hit) begin
            addr   = (row - m_act_y) * SPR_W + (col - m_act_x);
            m_addr = addr;
            w      = rom_mem[addr];
            if (w != KEY) begin
                r5 = (w >> 11) & 31;
                g6 = (w >> 5) & 63;
                b5 = w & 31;
                d_valid[0] = 1;
                d_r[0] = 8'((r5 << 3) | (r5 >> 2));
                d_g[0] = 8'((g6 << 2) | (g6 >> 4));
                d_b[0] = 8'((b5 << 3) | (b5 >> 2));
            end
        end
        if (h == 1599 && v == 479 && m_dirty) begin
            m_act_x = m_pend_x; m_act_y = m_pend_y; m_act_en = m_pend_en;
            m_dirty = 0;
        end
        if (wr) begin
            case (a)
                0: m_pend_x  = (m_pend_x & 'h300) | (d & 'hFF);
                1: m_pend_x  = (m_pend_x & 'hFF) | ((d & 3) << 8);
                2: m_pend_y  = (m_pend_y & 'h300) | (d & 'hFF);
                3: m_pend_y  = (m_pend_y & 'hFF) | ((d & 3) << 8);
                4: m_pend_en = d[0];
                default: ;
            endcase
            m_dirty = 1;
        end
    endtask

    task automatic checkOutput();
        checkValue("pix_valid", 16'(pix_valid), 16'(d_valid[2]));
        checkValue("pix_r", 16'(pix_r), 16'(d_r[2]));
        checkValue("pix_g", 16'(pix_g), 16'(d_g[2]));
        checkValue("pix_b", 16'(pix_b), 16'(d_b[2]));
        checkValue("rom_addr", 16'(rom_addr), 16'(m_addr));
    endtask

    task automatic applyStimulus(input int h, input int v, input bit cs, input bit wr, input int a, input int d);
        hcount     = 11'(h);
        vcount     = 10'(v);
        chipselect = cs;
        write      = wr;
        address    = 3'(a);
        writedata  = 8'(d);
        @(posedge clk);
        #1;
        modelEdge(h, v, cs && wr, a, d);
        checkOutput();
        if (pix_valid === 1'b1) vis_count++;
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    task automatic idle(input int h, input int v);
        applyStimulus(h, v, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic regWriteAt(input int a, input int d, input int h, input int v);
        applyStimulus(h, v, 1'b1, 1'b1, a, d);
    endtask

    task automatic regWrite(input int a, input int d);
        regWriteAt(a, d, 800, 200);
    endtask

    task automatic drain();
        repeat (3) idle(1500, 500);
    endtask

    task automatic frameBoundary();
        idle(1599, 479);
    endtask

    task automatic setSprite(input int x, input int y, input int en);
        regWrite(0, x & 255);
        regWrite(1, x >> 8);
        regWrite(2, y & 255);
        regWrite(3, y >> 8);
        regWrite(4, en);
    endtask

    task automatic scanCount(input string tag, input int v, input int h0, input int h1, input int expected);
        vis_count = 0;
        for (int h = h0; h <= h1; h++) idle(h, v);
        drain();
        checkValue(tag, 16'(vis_count), 16'(expected));
    endtask

    initial begin
        logic [15:0] w;
        int r, a, d, h, v;

        reset_n    = 1'b0;
        chipselect = 1'b0;
        write      = 1'b0;
        address    = '0;
        writedata  = '0;
        hcount     = '0;
        vcount     = '0;
        for (int i = 0; i < 1024; i++) begin
            w = 16'($urandom);
            if (w == KEY) w = w ^ 16'h0001;
            rom_mem[i] = w;
        end
        modelReset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkValue("reset_pix_valid", 16'(pix_valid), 16'h0);
        checkValue("reset_pix_r", 16'(pix_r), 16'h0);
        checkValue("reset_rom_addr", 16'(rom_addr), 16'h0);
        reset_n = 1'b1;

        // Mid-frame programming stays invisible until the frame boundary
        setSprite(100, 50, 1);
        scanCount("pre_commit_row50", 50, 190, 275, 0);
        frameBoundary();
        scanCount("row50_visible", 50, 190, 275, 64);
        scanCount("row49_empty", 49, 190, 275, 0);
        scanCount("row81_visible", 81, 190, 275, 64);
        scanCount("row82_empty", 82, 190, 275, 0);

        // Directed colours at col 100, row 50 (texel 0)
        rom_mem[0] = 16'hFFFF;
        idle(200, 50); idle(1500, 500); idle(1500, 500);
        checkValue("white_valid", 16'(pix_valid), 16'h1);
        checkValue("white_r", 16'(pix_r), 16'hFF);
        checkValue("white_g", 16'(pix_g), 16'hFF);
        checkValue("white_b", 16'(pix_b), 16'hFF);
        rom_mem[0] = 16'hF81F;
        idle(200, 50); idle(1500, 500); idle(1500, 500);
        checkValue("key_valid", 16'(pix_valid), 16'h0);
        checkValue("key_r", 16'(pix_r), 16'h0);
        rom_mem[0] = 16'h8410;
        idle(200, 50); idle(1500, 500); idle(1500, 500);
        checkValue("grey_r", 16'(pix_r), 16'h84);
        checkValue("grey_g", 16'(pix_g), 16'h82);
        checkValue("grey_b", 16'(pix_b), 16'h84);
        idle(210, 53);
        checkValue("rom_addr_105_53", 16'(rom_addr), 16'h065);
        drain();

        // Right edge clipping, hblank and no wrap to column 0
        setSprite(620, 50, 1);
        frameBoundary();
        scanCount("x620_right_edge", 50, 1230, 1310, 40);
        scanCount("x620_col0", 50, 0, 20, 0);
        setSprite(620, 470, 1);
        frameBoundary();
        scanCount("y470_row479", 479, 1230, 1310, 40);
        scanCount("y470_row0", 0, 1230, 1310, 0);

        // Write landing in the boundary cycle: old value this frame, new next
        setSprite(100, 50, 1);
        frameBoundary();
        regWrite(2, 60);
        regWriteAt(0, 200, 1599, 479);
        scanCount("boundary_old_x", 60, 190, 275, 64);
        scanCount("boundary_new_x_pending", 60, 390, 475, 0);
        frameBoundary();
        scanCount("boundary_new_x", 60, 390, 475, 64);
        scanCount("boundary_old_x_gone", 60, 190, 275, 0);

        // Randomized writes and raster positions
        for (int n = 0; n < 2000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 5) begin
                a = $urandom_range(0, 7);
                d = $urandom_range(0, 255);
                if (a == 1 || a == 3) d = d & 'hFD;
                if (a == 4) d = ($urandom_range(0, 3) != 0) ? 1 : 0;
                if (r < 1) regWriteAt(a, d, 1599, 479);
                else regWrite(a, d);
            end else if (r < 7) begin
                frameBoundary();
            end else if (r < 25) begin
                idle($urandom_range(0, 1599), $urandom_range(0, 524));
            end else begin
                h = (2 * m_act_x + $urandom_range(0, 90) + 1590) % 1600;
                v = (m_act_y + $urandom_range(0, 44) + 519) % 525;
                idle(h, v);
            end
        end
        drain();

        // Asynchronous reset while a pixel is being shown
        setSprite(100, 50, 1);
        frameBoundary();
        drain();
        rom_mem[0] = 16'h1234;
        idle(200, 50); idle(1500, 500); idle(1500, 500);
        checkValue("pre_reset_valid", 16'(pix_valid), 16'h1);
        #2;
        reset_n = 1'b0;
        #1;
        checkValue("async_reset_valid", 16'(pix_valid), 16'h0);
        checkValue("async_reset_r", 16'(pix_r), 16'h0);
        checkValue("async_reset_g", 16'(pix_g), 16'h0);
        checkValue("async_reset_b", 16'(pix_b), 16'h0);
        checkValue("async_reset_rom_addr", 16'(rom_addr), 16'h0);
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        scanCount("post_reset_disabled", 50, 190, 275, 0);
        frameBoundary();
        scanCount("post_reset_next_frame", 50, 190, 275, 0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
